network_dispatcher: RTL and testbench

One-to-four data distributor for the network switch fabric, the opposite direction of the 4-to-1 request-forwarding switch. It accepts one input word per cycle, tagged with a destination index. Each word is queued in a per-destination FIFO, and the four output ports present them under independent valid/ready handshakes. Words are never dropped: back-pressure from a full destination queue stalls the input.

---
 rtl/network_dispatcher.sv | 134 +++++++++++++
 tb/tb_network_dispatcher.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/network_dispatcher.sv
// network_dispatcher: one-to-four word distributor.
// Each input word is routed by in_dest into one of four first-word-fall-through
// FIFOs; every output port drains its FIFO under its own valid/ready handshake.
// A full destination queue stalls the input; no word is ever dropped.
// Optional feature macro: DISPATCH_BROADCAST_EN adds in_bcast, which writes the
// input word into all four queues at once when every queue has room.
module network_dispatcher #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [1:0]                           in_dest,
  input  logic [DATA_W-1:0]                    in_data,
`ifdef DISPATCH_BROADCAST_EN
  input  logic                                 in_bcast,
`endif
  output logic [3:0]                           out_valid,
  input  logic [3:0]                           out_ready,
  output logic [DATA_W-1:0]                    out_data [4],
  output logic [3:0][$clog2(DEPTH+1)-1:0]      out_level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  // Storage is deliberately not reset; out_data gating hides stale entries.
  logic [DATA_W-1:0]    mem_q [4][DEPTH];
  logic [3:0][PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [3:0][PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [3:0][LW-1:0]   level_q, level_d;
  logic [3:0]           full_s;
  logic [3:0]           push_s;
  logic [3:0]           pop_s;
  logic                 bcast_s;
  logic                 accept_s;

`ifdef DISPATCH_BROADCAST_EN
  assign bcast_s = in_bcast;
`else
  assign bcast_s = 1'b0;
`endif

  // Per-queue full flags derived from the occupancy counters.
  always_comb begin
    full_s = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      full_s[i] = (level_q[i] == FULL_LVL);
    end
  end

  // Input readiness: depends only on state, rst and in_dest/in_bcast, never on out_ready.
  always_comb begin
    in_ready = 1'b0;
    if (rst) begin
      in_ready = 1'b0;
    end else if (bcast_s) begin
      in_ready = ~|full_s;
    end else begin
      in_ready = ~full_s[in_dest];
    end
  end

  assign accept_s = in_valid & in_ready;

  // Push/pop decode and pointer/occupancy next-state for all four queues.
  always_comb begin
    push_s   = 4'b0000;
    pop_s    = 4'b0000;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    for (int i = 0; i < 4; i++) begin
      push_s[i] = accept_s & (bcast_s | (in_dest == 2'(i)));
      pop_s[i]  = out_valid[i] & out_ready[i];
      if (push_s[i]) begin
        wr_ptr_d[i] = wr_ptr_q[i] + PW'(1);
      end else begin
        wr_ptr_d[i] = wr_ptr_q[i];
      end
      if (pop_s[i]) begin
        rd_ptr_d[i] = rd_ptr_q[i] + PW'(1);
      end else begin
        rd_ptr_d[i] = rd_ptr_q[i];
      end
      case ({push_s[i], pop_s[i]})
        2'b10:   level_d[i] = level_q[i] + LW'(1);
        2'b01:   level_d[i] = level_q[i] - LW'(1);
        default: level_d[i] = level_q[i];
      endcase
    end
  end

  // Pointer and occupancy registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Queue storage write; push_s is already blocked during reset through in_ready.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (push_s[i]) begin
        mem_q[i][wr_ptr_q[i]] <= in_data;
      end
    end
  end

  // Output presentation: head word when the queue holds data, zeros otherwise.
  always_comb begin
    out_valid = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      out_valid[i] = (level_q[i] != {LW{1'b0}});
      if (out_valid[i]) begin
        out_data[i] = mem_q[i][rd_ptr_q[i]];
      end else begin
        out_data[i] = {DATA_W{1'b0}};
      end
    end
  end

  assign out_level = level_q;

endmodule

// File: tb/tb_network_dispatcher.sv
// Self-checking bench for network_dispatcher: directed scenarios plus a random
// phase, all compared against four behavioural word queues kept here.
module tb_network_dispatcher;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_dest;
  logic [DATA_W-1:0] in_data;
  logic              in_bcast;
  logic [3:0]        out_valid;
  logic [3:0]        out_ready;
  logic [DATA_W-1:0] out_data [4];
  logic [3:0][2:0]   out_level;

  int checks = 0;
  int errors = 0;

  // Reference model: one word queue per destination.
  logic [31:0] mq [4][$];

  always #5 clk = ~clk;

  network_dispatcher #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_dest   (in_dest),
    .in_data   (in_data),
`ifdef DISPATCH_BROADCAST_EN
    .in_bcast  (in_bcast),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_level (out_level)
  );

  function automatic bit model_ready();
    if (rst) return 1'b0;
    if (in_bcast) begin
      for (int i = 0; i < 4; i++) if (mq[i].size() >= DEPTH) return 1'b0;
      return 1'b1;
    end
    return mq[in_dest].size() < DEPTH;
  endfunction

  // Advance one clock edge and apply the same edge to the model.
  task automatic tick();
    bit acc;
    bit [3:0] pop;
    logic [31:0] w;
    acc = in_valid && model_ready();
    for (int i = 0; i < 4; i++) pop[i] = !rst && (mq[i].size() != 0) && out_ready[i];
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 4; i++) mq[i].delete();
    end else begin
      for (int i = 0; i < 4; i++) if (pop[i]) w = mq[i].pop_front();
      if (acc) begin
        if (in_bcast) for (int i = 0; i < 4; i++) mq[i].push_back(in_data);
        else mq[in_dest].push_back(in_data);
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 4'b0000; in_bcast = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_dest = 2'd2; in_data = 32'h0000_00EE;
    out_ready = 4'b0000; in_bcast = 1'b0;
    tick();
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_low: got %b expected 0", in_ready); end
    checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL reset_valid: got %b expected 0000", out_valid); end
    checks++; if (out_level !== 12'h000) begin errors++; $display("FAIL reset_level: got %h expected 000", out_level); end
    tick();
    rst = 1'b0;
    // Fill Q2 with three words, then reset mid-operation.
    for (int k = 0; k < 3; k++) begin
      in_data = 32'h0000_0020 + 32'(k);
      tick();
    end
    in_valid = 1'b0;
    #1;
    checks++; if (out_level[2] !== 3'd3) begin errors++; $display("FAIL reset_prefill_level: got %0d expected 3", out_level[2]); end
    rst = 1'b1; in_valid = 1'b1; out_ready = 4'b0100;
    tick();
    rst = 1'b0; in_dest = 2'd2;
    #1;
    checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL reset_mid_valid: got %b expected 0000", out_valid); end
    checks++; if (out_level !== 12'h000) begin errors++; $display("FAIL reset_mid_level: got %h expected 000", out_level); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (out_data[i] !== 32'h0) begin errors++; $display("FAIL reset_mid_data%0d: got %h expected 0", i, out_data[i]); end
    end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b expected 1", in_ready); end
    in_valid = 1'b0; out_ready = 4'b0000;
  endtask

  task automatic test_unicast();
    do_reset();
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_dest = 2'(k); in_data = 32'hA0 + 32'(k);
      tick();
    end
    in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 4'b1111) begin errors++; $display("FAIL unicast_valid: got %b expected 1111", out_valid); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (out_data[i] !== 32'hA0 + 32'(i)) begin errors++; $display("FAIL unicast_data%0d: got %h expected %h", i, out_data[i], 32'hA0 + 32'(i)); end
      checks++; if (out_level[i] !== 3'd1) begin errors++; $display("FAIL unicast_level%0d: got %0d expected 1", i, out_level[i]); end
    end
  endtask

  task automatic test_full_backpressure();
    do_reset();
    in_valid = 1'b1; in_dest = 2'd1;
    for (int k = 0; k < 4; k++) begin
      in_data = 32'h10 + 32'(k);
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_accept%0d: got %b expected 1", k, in_ready); end
      tick();
    end
    in_data = 32'h14;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready: got %b expected 0", in_ready); end
    checks++; if (out_level[1] !== 3'd4) begin errors++; $display("FAIL bp_full_level: got %0d expected 4", out_level[1]); end
    tick();
    out_ready = 4'b0010;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_pop_ready: got %b expected 0", in_ready); end
    checks++; if (out_data[1] !== 32'h10) begin errors++; $display("FAIL bp_pop_head: got %h expected 10", out_data[1]); end
    tick();
    out_ready = 4'b0000;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_retry_ready: got %b expected 1", in_ready); end
    checks++; if (out_level[1] !== 3'd3) begin errors++; $display("FAIL bp_after_pop_level: got %0d expected 3", out_level[1]); end
    tick();
    in_valid = 1'b0;
    #1;
    checks++; if (out_level[1] !== 3'd4) begin errors++; $display("FAIL bp_retry_level: got %0d expected 4", out_level[1]); end
    out_ready = 4'b0010;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (out_data[1] !== 32'h11 + 32'(k)) begin errors++; $display("FAIL bp_drain%0d: got %h expected %h", k, out_data[1], 32'h11 + 32'(k)); end
      tick();
    end
    #1;
    checks++; if (out_valid[1] !== 1'b0) begin errors++; $display("FAIL bp_drained_valid: got %b expected 0", out_valid[1]); end
    out_ready = 4'b0000;
  endtask

  task automatic test_push_pop();
    do_reset();
    in_valid = 1'b1; in_dest = 2'd3;
    for (int k = 0; k < 2; k++) begin
      in_data = 32'h300 + 32'(k);
      tick();
    end
    out_ready = 4'b1000;
    for (int k = 0; k < 8; k++) begin
      in_data = 32'h302 + 32'(k);
      #1;
      checks++; if (out_level[3] !== 3'd2) begin errors++; $display("FAIL pp_level%0d: got %0d expected 2", k, out_level[3]); end
      checks++; if (out_data[3] !== 32'h300 + 32'(k)) begin errors++; $display("FAIL pp_data%0d: got %h expected %h", k, out_data[3], 32'h300 + 32'(k)); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL pp_ready%0d: got %b expected 1", k, in_ready); end
      tick();
    end
    in_valid = 1'b0; out_ready = 4'b0000;
  endtask

  task automatic test_head_of_line();
    do_reset();
    in_valid = 1'b1; in_dest = 2'd0;
    for (int k = 0; k < 4; k++) begin
      in_data = 32'h200 + 32'(k);
      tick();
    end
    in_dest = 2'd2; in_data = 32'h55;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL hol_ready: got %b expected 1", in_ready); end
    tick();
    in_valid = 1'b0;
    #1;
    checks++; if (out_valid[2] !== 1'b1) begin errors++; $display("FAIL hol_valid: got %b expected 1", out_valid[2]); end
    checks++; if (out_data[2] !== 32'h55) begin errors++; $display("FAIL hol_data: got %h expected 55", out_data[2]); end
    checks++; if (out_level[0] !== 3'd4) begin errors++; $display("FAIL hol_q0_level: got %0d expected 4", out_level[0]); end
  endtask

`ifdef DISPATCH_BROADCAST_EN
  task automatic test_broadcast();
    do_reset();
    in_valid = 1'b1; in_dest = 2'd1;
    for (int k = 0; k < 4; k++) begin
      in_data = 32'h100 + 32'(k);
      tick();
    end
    in_bcast = 1'b1; in_dest = 2'd0; in_data = 32'hFFFF0000;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bc_stall: got %b expected 0", in_ready); end
    tick();
    out_ready = 4'b0010;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bc_stall_pop: got %b expected 0", in_ready); end
    tick();
    out_ready = 4'b0000;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bc_ready: got %b expected 1", in_ready); end
    tick();
    in_valid = 1'b0; in_bcast = 1'b0;
    #1;
    checks++; if (out_level !== {3'd1, 3'd1, 3'd4, 3'd1}) begin errors++; $display("FAIL bc_levels: got %h expected %h", out_level, {3'd1, 3'd1, 3'd4, 3'd1}); end
    checks++; if (out_data[0] !== 32'hFFFF0000) begin errors++; $display("FAIL bc_q0_head: got %h expected ffff0000", out_data[0]); end
    out_ready = 4'b0010;
    for (int k = 0; k < 3; k++) tick();
    out_ready = 4'b0000;
    #1;
    checks++; if (out_data[1] !== 32'hFFFF0000) begin errors++; $display("FAIL bc_q1_tail: got %h expected ffff0000", out_data[1]); end
  endtask
`endif

  task automatic test_random();
    int exp_size;
    logic [31:0] exp_data;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_dest  = 2'($urandom_range(0, 3));
      in_data  = $urandom;
`ifdef DISPATCH_BROADCAST_EN
      in_bcast = ($urandom_range(0, 9) == 0);
`endif
      if (c < 200) out_ready = 4'($urandom & $urandom);
      else         out_ready = 4'($urandom | $urandom);
      #1;
      checks++; if (in_ready !== model_ready()) begin errors++; $display("FAIL rnd_ready c%0d: got %b expected %b", c, in_ready, model_ready()); end
      for (int i = 0; i < 4; i++) begin
        exp_size = mq[i].size();
        exp_data = (exp_size != 0) ? mq[i][0] : 32'h0;
        checks++; if (out_level[i] !== 3'(exp_size)) begin errors++; $display("FAIL rnd_level%0d c%0d: got %0d expected %0d", i, c, out_level[i], exp_size); end
        checks++; if (out_valid[i] !== (exp_size != 0)) begin errors++; $display("FAIL rnd_valid%0d c%0d: got %b expected %b", i, c, out_valid[i], exp_size != 0); end
        checks++; if (out_data[i] !== exp_data) begin errors++; $display("FAIL rnd_data%0d c%0d: got %h expected %h", i, c, out_data[i], exp_data); end
      end
      tick();
    end
    in_valid = 1'b0; in_bcast = 1'b0; out_ready = 4'b0000;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_dest = 2'd0; in_data = 32'h0;
    in_bcast = 1'b0; out_ready = 4'b0000;
    #2;
    test_reset();
    test_unicast();
    test_full_backpressure();
    test_push_pop();
    test_head_of_line();
`ifdef DISPATCH_BROADCAST_EN
    test_broadcast();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
